// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: access-size encodings and data width.
// Optional build macro DMEM_MISALIGN_CHECK_EN (used by data_memory) relies on isMisaligned.
package mips_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LANES      = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        BHW_BYTE  = 2'd0,
        BHW_HALF  = 2'd1,
        BHW_WORD  = 2'd2,
        BHW_WORD3 = 2'd3
    } bhw_e;

    // Encoding 3 behaves as a word access everywhere.
    function automatic logic isMisaligned(input logic [1:0] bhw, input logic [1:0] byteOffset);
        logic result;
        result = 1'b0;
        case (bhw_e'(bhw))
            BHW_BYTE:  result = 1'b0;
            BHW_HALF:  result = byteOffset[0];
            default:   result = (byteOffset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Pure combinational lane steering for data_memory: store byte mask / lane data,
// and load extraction with zero/sign extension.
module dmem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]            bhw,
    input  logic [1:0]            byteOffset,
    input  logic                  extendSign,
    input  logic [DATA_WIDTH-1:0] storeData,
    input  logic [DATA_WIDTH-1:0] rawWord,
    output logic [LANES-1:0]      writeMask,
    output logic [DATA_WIDTH-1:0] laneData,
    output logic [DATA_WIDTH-1:0] loadData
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Store side: replicate the sub-word so every candidate lane already holds it.
    always_comb begin
        writeMask = '1;
        laneData  = storeData;
        case (bhw_e'(bhw))
            BHW_BYTE: begin
                writeMask = 4'b0001 << byteOffset;
                laneData  = {4{storeData[7:0]}};
            end
            BHW_HALF: begin
                writeMask = byteOffset[1] ? 4'b1100 : 4'b0011;
                laneData  = {2{storeData[15:0]}};
            end
            default: begin
                writeMask = 4'b1111;
                laneData  = storeData;
            end
        endcase
    end

    always_comb begin
        selByte = rawWord[7:0];
        case (byteOffset)
            2'd0:    selByte = rawWord[7:0];
            2'd1:    selByte = rawWord[15:8];
            2'd2:    selByte = rawWord[23:16];
            default: selByte = rawWord[31:24];
        endcase
        selHalf = byteOffset[1] ? rawWord[31:16] : rawWord[15:0];
    end

    always_comb begin
        loadData = rawWord;
        case (bhw_e'(bhw))
            BHW_BYTE: loadData = {{24{extendSign & selByte[7]}}, selByte};
            BHW_HALF: loadData = {{16{extendSign & selHalf[15]}}, selHalf};
            default:  loadData = rawWord;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory: combinational reads, synchronous writes, async clear.
// Define DMEM_MISALIGN_CHECK_EN to add the Misaligned output and suppress misaligned accesses.
module data_memory
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            BHW,
    input  logic                  ExtendSign,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic                  Misaligned,
`endif
    output logic [DATA_WIDTH-1:0] ReadData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0]  wordIdx;
    logic [1:0]            byteOffset;
    logic [LANES-1:0]      writeMask;
    logic [DATA_WIDTH-1:0] laneData;
    logic [DATA_WIDTH-1:0] rawWord;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  accessOk;
    logic                  writeEn;
    logic                  unusedAddr;

    // High address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
    assign wordIdx    = Address[ADDR_BITS+1:2];
    assign byteOffset = Address[1:0];
    assign unusedAddr = ^Address[DATA_WIDTH-1:ADDR_BITS+2];
    assign rawWord    = mem[wordIdx];

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        Misaligned = (MemRead | MemWrite) & isMisaligned(BHW, byteOffset);
        accessOk   = ~isMisaligned(BHW, byteOffset);
    end
`else
    assign accessOk = 1'b1;
`endif

    assign writeEn = MemWrite & accessOk;

    dmem_lane_align u_lane_align (
        .bhw        (BHW),
        .byteOffset (byteOffset),
        .extendSign (ExtendSign),
        .storeData  (WriteData),
        .rawWord    (rawWord),
        .writeMask  (writeMask),
        .laneData   (laneData),
        .loadData   (loadData)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (writeEn) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (writeMask[k]) begin
                    mem[wordIdx][8*k +: 8] <= laneData[8*k +: 8];
                end
            end
        end
    end

    // No write bypass: a same-cycle read sees the pre-edge contents.
    always_comb begin
        ReadData = '0;
        if (MemRead && accessOk) begin
            ReadData = loadData;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (default and DMEM_MISALIGN_CHECK_EN builds).
module tb_data_memory;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  BHW;
    logic        ExtendSign;
    logic [31:0] ReadData;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        Misaligned;
`endif

    int checks = 0;
    int errors = 0;

    data_memory #(
        .DEPTH     (256),
        .ADDR_BITS (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .BHW        (BHW),
        .ExtendSign (ExtendSign),
`ifdef DMEM_MISALIGN_CHECK_EN
        .Misaligned (Misaligned),
`endif
        .ReadData   (ReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic storeOp(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        @(negedge Clk);
        Address   = addr;
        WriteData = data;
        BHW       = size;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(posedge Clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic loadCheck(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic sext, input logic [31:0] expected);
        @(negedge Clk);
        Address    = addr;
        BHW        = size;
        ExtendSign = sext;
        MemRead    = 1'b1;
        #1;
        check(tag, ReadData, expected);
    endtask

    initial begin
        Reset      = 1'b0;
        Address    = 32'h10;
        WriteData  = '0;
        MemWrite   = 1'b0;
        MemRead    = 1'b1;
        BHW        = 2'd2;
        ExtendSign = 1'b0;
        #3;
        check("reset_read", ReadData, 32'h0);

        // Reset clears stored data asynchronously and blocks writes.
        @(negedge Clk);
        Reset = 1'b1;
        storeOp(32'h10, 32'hDEADBEEF, 2'd2);
        loadCheck("pre_reset_word", 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        #1;
        Reset = 1'b0;
        #1;
        check("async_clear", ReadData, 32'h0);
        MemWrite  = 1'b1;
        WriteData = 32'h5A5A5A5A;
        @(posedge Clk);
        #1;
        MemWrite = 1'b0;
        check("write_in_reset", ReadData, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        loadCheck("post_reset_word", 32'h10, 2'd2, 1'b0, 32'h0);

        // Word round trip.
        storeOp(32'h20, 32'h12345678, 2'd2);
        loadCheck("word_rt", 32'h20, 2'd2, 1'b1, 32'h12345678);
        MemRead = 1'b0;
        #1;
        check("memread_off", ReadData, 32'h0);

        // Byte store keeps other lanes.
        storeOp(32'h40, 32'h11223344, 2'd2);
        storeOp(32'h41, 32'hFFFFFFAB, 2'd0);
        loadCheck("byte_lane_word", 32'h40, 2'd2, 1'b0, 32'h1122AB44);
        loadCheck("byte_signed",    32'h41, 2'd0, 1'b1, 32'hFFFFFFAB);
        loadCheck("byte_unsigned",  32'h41, 2'd0, 1'b0, 32'h000000AB);
        loadCheck("byte_lane0",     32'h40, 2'd0, 1'b1, 32'h00000044);
        loadCheck("byte_lane3",     32'h43, 2'd0, 1'b1, 32'h00000011);

        // Halfword store into upper half.
        storeOp(32'h42, 32'hFFFF8001, 2'd1);
        loadCheck("half_word",     32'h40, 2'd2, 1'b0, 32'h8001AB44);
        loadCheck("half_signed",   32'h42, 2'd1, 1'b1, 32'hFFFF8001);
        loadCheck("half_unsigned", 32'h42, 2'd1, 1'b0, 32'h00008001);
        loadCheck("half_low_sx",   32'h40, 2'd1, 1'b1, 32'hFFFFAB44);
        loadCheck("bhw3_word",     32'h40, 2'd3, 1'b1, 32'h8001AB44);

        // Address wrap modulo 1 KiB.
        storeOp(32'h400, 32'hCAFEF00D, 2'd2);
        loadCheck("wrap_read0",   32'h000, 2'd2, 1'b0, 32'hCAFEF00D);
        loadCheck("wrap_read400", 32'h400, 2'd2, 1'b0, 32'hCAFEF00D);

        // Same-cycle read and write: old value before the edge, new after.
        @(negedge Clk);
        Address   = 32'h0;
        BHW       = 2'd2;
        WriteData = 32'h01020304;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        #1;
        check("rw_before_edge", ReadData, 32'hCAFEF00D);
        @(posedge Clk);
        #1;
        MemWrite = 1'b0;
        check("rw_after_edge", ReadData, 32'h01020304);

        // No write without MemWrite.
        @(negedge Clk);
        WriteData = 32'hFFFFFFFF;
        @(posedge Clk);
        #1;
        check("no_memwrite", ReadData, 32'h01020304);

`ifdef DMEM_MISALIGN_CHECK_EN
        @(negedge Clk);
        Address   = 32'h22;
        BHW       = 2'd2;
        WriteData = 32'h55555555;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        #1;
        check("mis_word_flag", {31'b0, Misaligned}, 32'h1);
        @(posedge Clk);
        #1;
        MemWrite = 1'b0;
        loadCheck("mis_word_unchanged", 32'h20, 2'd2, 1'b0, 32'h12345678);
        check("aligned_flag", {31'b0, Misaligned}, 32'h0);
        loadCheck("mis_half_read", 32'h23, 2'd1, 1'b0, 32'h0);
        check("mis_half_flag", {31'b0, Misaligned}, 32'h1);
        MemRead = 1'b0;
        #1;
        check("mis_idle_flag", {31'b0, Misaligned}, 32'h0);
`else
        // Misaligned half store silently aligns to lanes 2..3.
        storeOp(32'h43, 32'h0000BEEF, 2'd1);
        loadCheck("unaligned_half", 32'h40, 2'd2, 1'b0, 32'hBEEFAB44);
        loadCheck("unaligned_word", 32'h23, 2'd2, 1'b0, 32'h12345678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
